// File: rtl/alu_cmd_sequencer.sv
// Purpose: clocked valid/ready command front-end for a 4-bit combinational ALU, holding a registered response.
// Latency: response valid SETTLE_CYCLES+1 cycles after the accept cycle; one op every SETTLE_CYCLES+1 cycles back-to-back.
// Backpressure: a stalled response (rsp_valid & !rsp_ready) freezes rsp_* and the ALU inputs and holds cmd_ready low.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 1,   // ALU input hold time before capture, 1..15
    parameter int CNT_W         = 8    // completed-operation counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    // command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    // ALU drive
    output logic             alu_sel0,
    output logic             alu_sel1,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    // ALU observe
    input  logic [4:0]       alu_result,
    input  logic [3:0]       alu_answer,
    input  logic             alu_eq,
    input  logic             alu_less,
    input  logic             alu_great,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_data,
    output logic [2:0]       rsp_flags,
    output logic [1:0]       rsp_op,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Settle counter counts down to zero; zero marks the capture cycle.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       rsp_fire;
    logic [1:0] op_cur;
    logic [4:0] cap_data;

    // Ready only depends on state and rsp_ready, never on cmd_valid; gated low in reset.
    assign cmd_ready = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
    assign accept    = cmd_valid & cmd_ready;
    assign capture   = (state == SETTLE) && (cnt == 4'd0);
    assign rsp_valid = (state == RESP);
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign op_cur    = {alu_sel1, alu_sel0};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: settle countdown, then hold the response until it is taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) state_nxt = cmd_valid ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle countdown: load on accept, decrement while settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if ((state == SETTLE) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // ALU inputs are registered on accept and held until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel0 <= 1'b0;
            alu_sel1 <= 1'b0;
            alu_a    <= 4'd0;
            alu_b    <= 4'd0;
        end else if (accept) begin
            alu_sel0 <= cmd_op[0];
            alu_sel1 <= cmd_op[1];
            alu_a    <= cmd_a;
            alu_b    <= cmd_b;
        end
    end

    // Pick the ALU output that belongs to the op currently driven.
    always_comb begin
        cap_data = 5'd0;
        case (op_cur)
            2'b00, 2'b01: cap_data = alu_result;
            2'b10:        cap_data = {2'b00, alu_great, alu_less, alu_eq};
            2'b11:        cap_data = {1'b0, alu_answer};
            default:      cap_data = 5'd0;
        endcase
    end

    // Response capture on the last settle cycle; held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= 5'd0;
            rsp_flags <= 3'd0;
            rsp_op    <= 2'd0;
        end else if (capture) begin
            rsp_data  <= cap_data;
            rsp_flags <= {alu_great, alu_less, alu_eq};
            rsp_op    <= op_cur;
        end
    end

    // Completed-response counter, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- DUT with SETTLE_CYCLES = 1 ----------------
    logic       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [1:0] cmd_op, rsp_op;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_answer;
    logic       alu_sel0, alu_sel1, alu_eq, alu_less, alu_great;
    logic [4:0] alu_result, rsp_data;
    logic [2:0] rsp_flags;
    logic [7:0] op_count;

    alu_cmd_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_sel0(alu_sel0), .alu_sel1(alu_sel1), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_answer(alu_answer),
        .alu_eq(alu_eq), .alu_less(alu_less), .alu_great(alu_great),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_op(rsp_op), .op_count(op_count)
    );

    // Stub ALU
    assign alu_result = alu_sel0 ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_answer = alu_a & alu_b;
    assign alu_eq     = (alu_a == alu_b);
    assign alu_less   = (alu_a <  alu_b);
    assign alu_great  = (alu_a >  alu_b);

    // ---------------- DUT with SETTLE_CYCLES = 4 ----------------
    logic       rst4_n, cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4;
    logic [1:0] cmd_op4, rsp_op4;
    logic [3:0] cmd_a4, cmd_b4, alu_a4, alu_b4, alu_answer4;
    logic       alu_sel0_4, alu_sel1_4, alu_eq4, alu_less4, alu_great4;
    logic [4:0] alu_result4, rsp_data4;
    logic [2:0] rsp_flags4;
    logic [7:0] op_count4;

    alu_cmd_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op4), .cmd_a(cmd_a4), .cmd_b(cmd_b4),
        .alu_sel0(alu_sel0_4), .alu_sel1(alu_sel1_4), .alu_a(alu_a4), .alu_b(alu_b4),
        .alu_result(alu_result4), .alu_answer(alu_answer4),
        .alu_eq(alu_eq4), .alu_less(alu_less4), .alu_great(alu_great4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
        .rsp_flags(rsp_flags4), .rsp_op(rsp_op4), .op_count(op_count4)
    );

    assign alu_result4 = alu_sel0_4 ? ({1'b0, alu_a4} - {1'b0, alu_b4}) : ({1'b0, alu_a4} + {1'b0, alu_b4});
    assign alu_answer4 = alu_a4 & alu_b4;
    assign alu_eq4     = (alu_a4 == alu_b4);
    assign alu_less4   = (alu_a4 <  alu_b4);
    assign alu_great4  = (alu_a4 >  alu_b4);

    logic [7:0] exp_count;
    logic [3:0] va, vb;
    logic [4:0] exp_sum;

    initial begin
        // ---- 1. reset with cmd_valid asserted ----
        rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd9; cmd_b = 4'd2; rsp_ready = 1'b0;
        rst4_n = 1'b0; cmd_valid4 = 1'b0; cmd_op4 = 2'b00; cmd_a4 = 4'd0; cmd_b4 = 4'd0; rsp_ready4 = 1'b0;
        @(negedge clk);
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_op", rsp_op, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_ab", {alu_sel1, alu_sel0, alu_a, alu_b}, 0);
        cmd_valid = 1'b0;
        rst_n = 1'b1; rst4_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst4_cmd_ready", cmd_ready4, 1);
        tick();

        // ---- 2. add 5+3 ----
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd5; cmd_b = 4'd3;
        check("add_cmd_ready", cmd_ready, 1);
        tick();                               // accept edge
        cmd_valid = 1'b0;
        check("add_alu_a", alu_a, 5);
        check("add_alu_b", alu_b, 3);
        check("add_sel", {alu_sel1, alu_sel0}, 0);
        check("add_rsp_valid_early", rsp_valid, 0);
        tick();
        check("add_rsp_valid", rsp_valid, 1);
        check("add_rsp_data", rsp_data, 5'h08);
        check("add_rsp_op", rsp_op, 0);
        check("add_rsp_flags", rsp_flags, 3'b100);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("add_op_count", op_count, 1);
        check("add_rsp_valid_drop", rsp_valid, 0);

        // ---- 3. AND C & A ----
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_a = 4'hC; cmd_b = 4'hA;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("and_rsp_valid", rsp_valid, 1);
        check("and_rsp_data", rsp_data, 5'h08);
        check("and_rsp_flags", rsp_flags, 3'b100);
        check("and_rsp_op", rsp_op, 2'b11);

        // ---- 4. back-pressure with a pending command ----
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 4'd7; cmd_b = 4'd7;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 5'h08);
            check("bp_rsp_op", rsp_op, 2'b11);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_alu_ab", {alu_a, alu_b}, 8'hCA);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        check("bp_op_count", op_count, 2);
        check("bp_new_alu_ab", {alu_a, alu_b}, 8'h77);
        check("bp_new_sel", {alu_sel1, alu_sel0}, 2'b10);
        check("bp_settle_valid", rsp_valid, 0);
        tick();
        check("cmp_rsp_valid", rsp_valid, 1);
        check("cmp_rsp_data", rsp_data, 5'b00001);
        check("cmp_rsp_flags", rsp_flags, 3'b001);
        check("cmp_rsp_op", rsp_op, 2'b10);
        rsp_ready = 1'b1;
        tick();
        check("cmp_op_count", op_count, 3);

        // ---- 5. 256 back-to-back adds ----
        exp_count = 8'd3;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 4'd0; cmd_b = 4'd0;
        tick();                               // accept op 0
        for (int i = 0; i < 256; i++) begin
            va = i[3:0]; vb = i[7:4];
            exp_sum = {1'b0, va} + {1'b0, vb};
            check("b2b_settle_valid", rsp_valid, 0);
            if (i < 255) begin
                cmd_a = 4'((i + 1) % 16);
                cmd_b = 4'((i + 1) / 16);
            end else begin
                cmd_valid = 1'b0;
            end
            tick();
            check("b2b_rsp_valid", rsp_valid, 1);
            check("b2b_rsp_data", rsp_data, exp_sum);
            tick();
            exp_count = exp_count + 8'd1;
            check("b2b_op_count", op_count, exp_count);
            if (exp_count == 8'd0) check("b2b_wrap", op_count, 0);
        end
        check("b2b_idle_valid", rsp_valid, 0);
        check("b2b_idle_ready", cmd_ready, 1);
        rsp_ready = 1'b0;

        // ---- 6. reset during SETTLE on the 4-cycle instance ----
        cmd_valid4 = 1'b1; cmd_op4 = 2'b00; cmd_a4 = 4'd1; cmd_b4 = 4'd2; rsp_ready4 = 1'b1;
        tick();
        cmd_valid4 = 1'b0;
        tick();
        check("r6_mid_settle", rsp_valid4, 0);
        rst4_n = 1'b0;
        #1;
        check("r6_rst_cmd_ready", cmd_ready4, 0);
        check("r6_rst_valid", rsp_valid4, 0);
        check("r6_rst_count", op_count4, 0);
        tick();
        rst4_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("r6_no_rsp", rsp_valid4, 0);
            tick();
        end
        check("r6_count_after", op_count4, 0);
        cmd_valid4 = 1'b1; cmd_a4 = 4'd6; cmd_b4 = 4'd7; rsp_ready4 = 1'b0;
        check("r6_fresh_ready", cmd_ready4, 1);
        tick();
        cmd_valid4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("r6_settle_valid", rsp_valid4, 0);
            tick();
        end
        check("r6_rsp_valid", rsp_valid4, 1);
        check("r6_rsp_data", rsp_data4, 5'h0D);
        rsp_ready4 = 1'b1;
        tick();
        check("r6_op_count", op_count4, 1);
        check("r6_valid_drop", rsp_valid4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the run stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no end, expected finish before 200000");
        $fatal(1);
    end

endmodule
